shift_reg_n: RTL and testbench
==============================

SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 Parameter WIDTH, default 9: register width in bits; legal values are 2 to 32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift toward MSB (left), 0 = shift toward LSB (right).
REQ-003 Port Clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port Load, input, 1 bit: parallel load of D.
REQ-006 Port D, input, WIDTH bits: parallel load data.
REQ-007 Port Shift_En, input, 1 bit: single-step shift, honoured only in IDLE.
REQ-008 Port Start, input, 1 bit: begin an automatic burst of WIDTH shifts.
REQ-009 Port Mode, input, 2 bits: fill bit source; 00 = zero fill, 01 = rotate, 10 = Serial_In, 11 = zero fill.
REQ-010 Port Serial_In, input, 1 bit: serial data shifted in when Mode = 10.
REQ-011 Port Data_Out, output, WIDTH bits: register contents.
REQ-012 Port Serial_Out, output, 1 bit: combinational; Data_Out[WIDTH-1] if MSB_FIRST = 1, else Data_Out[0].
REQ-013 Port Busy, output, 1 bit: high while the FSM is in SHIFT.
REQ-014 Port Done, output, 1 bit: one-cycle pulse when a burst completes.
REQ-015 Port Bit_Cnt, output, $clog2(WIDTH+1) bits: number of shifts completed in the current or last burst.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 One shift step SHALL do the following:
- MSB_FIRST = 1: Data_Out <= {Data_Out[WIDTH-2:0], fill}.
- MSB_FIRST = 0: Data_Out <= {fill, Data_Out[WIDTH-1:1]}.
- fill = 0 for Mode 00 or 11; fill = the outgoing bit (Serial_Out) for Mode 01; fill = Serial_In for Mode 10.
REQ-018 In IDLE, priority SHALL be Load > Start > Shift_En; only the highest-priority asserted input takes effect.
REQ-019 IDLE with Load: Data_Out <= D; Bit_Cnt <= 0; state stays IDLE.
REQ-020 IDLE with Start (Load low): state <= SHIFT; Bit_Cnt <= 0; Data_Out unchanged (the start edge performs no shift).
REQ-021 IDLE with Shift_En only: perform one shift step; Bit_Cnt unchanged; no Done pulse.
REQ-022 In SHIFT, every edge SHALL perform one shift step and increment Bit_Cnt; Mode is sampled on each edge.
REQ-023 In SHIFT, the edge on which Bit_Cnt = WIDTH-1 SHALL perform the last shift, set Bit_Cnt to WIDTH and move to DONE; a burst is exactly WIDTH shifts and Busy is high for exactly WIDTH cycles.
REQ-024 DONE SHALL assert Done for exactly one cycle and return to IDLE unconditionally; Data_Out and Bit_Cnt are held.
REQ-025 Start and Shift_En SHALL be ignored in SHIFT and DONE.
REQ-026 Load in SHIFT SHALL abort the burst: Data_Out <= D; Bit_Cnt <= 0; state <= IDLE; no Done pulse.
REQ-027 Load in DONE SHALL load D and clear Bit_Cnt; the Done pulse for that cycle is still asserted.
REQ-028 Holding Start high continuously SHALL produce back-to-back bursts, each separated by one DONE cycle and one IDLE start cycle.
REQ-029 Bit_Cnt SHALL never exceed WIDTH.

Reset
REQ-030 Reset_n low SHALL immediately, without waiting for a Clk edge, force state = IDLE, Data_Out = 0, Bit_Cnt = 0, Busy = 0 and Done = 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no Done pulse; the first edge after reset release SHALL observe IDLE-state rules.

Verification
REQ-032 Each scenario below uses WIDTH = 9 and MSB_FIRST = 1 unless stated otherwise.
- Load D = 9'h1A5, then one Shift_En with Mode = 00 -> Data_Out = 9'h14A, Serial_Out goes from 1 to 1, Busy stays 0, Done stays 0.
- Load 9'h1A5, pulse Start with Mode = 01 -> Busy high for 9 cycles, Serial_Out emits 1,1,0,1,0,0,1,0,1, Done pulses once, Data_Out = 9'h1A5, Bit_Cnt = 9.
- Load 0, pulse Start with Mode = 10 and Serial_In driving 1,0,1,1,0,0,1,1,1 on the 9 shift edges -> Data_Out = 9'h167 when Done is high.
- Load 9'h1A5 and Start; on the 4th shift edge assert Load with D = 9'h0F0 -> Data_Out = 9'h0F0, Bit_Cnt = 0, IDLE, no Done pulse. Separately, assert Reset_n low mid-burst -> all outputs 0 asynchronously, before the next Clk edge.
- MSB_FIRST = 0: load 9'h001, Start with Mode = 00 -> Serial_Out emits 1 then 0 x8, final Data_Out = 0. With Load, Start and Shift_En all high in IDLE, only the load occurs.

Source files
------------

// File: rtl/shift_reg_n_if.sv
// Bus bundle for shift_reg_n: control, parallel/serial data and status.
// The master drives the load, shift, start, mode and serial inputs.
// The slave (the register) drives the data and status outputs.
interface shift_reg_n_if #(
    parameter int WIDTH = 9
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             Load;
    logic [WIDTH-1:0] D;
    logic             Shift_En;
    logic             Start;
    logic [1:0]       Mode;
    logic             Serial_In;
    logic [WIDTH-1:0] Data_Out;
    logic             Serial_Out;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Bit_Cnt;

    modport master (
        output Load, D, Shift_En, Start, Mode, Serial_In,
        input  Data_Out, Serial_Out, Busy, Done, Bit_Cnt
    );

    modport slave (
        input  Load, D, Shift_En, Start, Mode, Serial_In,
        output Data_Out, Serial_Out, Busy, Done, Bit_Cnt
    );
endinterface

// File: rtl/shift_reg_n.sv
// Shift register with parallel load, single-step shift and WIDTH-step burst FSM.
// Latency: every update lands on the next Clk edge; Serial_Out is combinational.
// No backpressure: Load always wins, Start/Shift_En are ignored while a burst runs.
module shift_reg_n #(
    parameter int WIDTH     = 9,
    parameter int MSB_FIRST = 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    shift_reg_n_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             out_bit;
    logic             fill;
    logic [WIDTH-1:0] shifted;

    // Direction is fixed at elaboration; out_bit is the bit leaving the register.
    if (MSB_FIRST != 0) begin : g_msb
        assign out_bit = data_q[WIDTH-1];
        assign shifted = {data_q[WIDTH-2:0], fill};
    end else begin : g_lsb
        assign out_bit = data_q[0];
        assign shifted = {fill, data_q[WIDTH-1:1]};
    end

    // Fill source: rotate feeds the outgoing bit back in; 00 and 11 both zero-fill.
    always_comb begin
        fill = 1'b0;
        case (bus.Mode)
            2'b01:   fill = out_bit;
            2'b10:   fill = bus.Serial_In;
            default: fill = 1'b0;
        endcase
    end

    // Next-state logic: Load dominates everywhere; Start/Shift_En only act in IDLE.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Load) begin
                    data_d = bus.D;
                    cnt_d  = '0;
                end else if (bus.Start) begin
                    // The start edge only arms the burst; no shift happens here.
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else if (bus.Shift_En) begin
                    data_d = shifted;
                end
            end
            SHIFT: begin
                if (bus.Load) begin
                    // Abort: back to IDLE without passing through DONE.
                    data_d  = bus.D;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    data_d = shifted;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.Load) begin
                    data_d = bus.D;
                    cnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, data and count registers; reset clears them without a clock.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status decodes straight from state so reset drops them immediately.
    assign bus.Data_Out   = data_q;
    assign bus.Serial_Out = out_bit;
    assign bus.Busy       = (state_q == SHIFT);
    assign bus.Done       = (state_q == DONE);
    assign bus.Bit_Cnt    = cnt_q;
endmodule

// File: tb/tb_shift_reg_n.sv
// Directed bench for shift_reg_n: MSB-first and LSB-first instances.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_shift_reg_n;
    logic Clk;
    logic Reset_n;

    int n_chk;
    int n_pass;

    shift_reg_n_if #(.WIDTH(9)) ifa ();
    shift_reg_n_if #(.WIDTH(9)) ifb ();

    shift_reg_n #(.WIDTH(9), .MSB_FIRST(1)) u_dut_msb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (ifa)
    );

    shift_reg_n #(.WIDTH(9), .MSB_FIRST(0)) u_dut_lsb (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (ifb)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [8:0] exp_bits;
        logic [8:0] sin_bits;
        int busy_n;
        int done_n;

        n_chk  = 0;
        n_pass = 0;

        ifa.Load = 0; ifa.D = '0; ifa.Shift_En = 0; ifa.Start = 0; ifa.Mode = 2'b00; ifa.Serial_In = 0;
        ifb.Load = 0; ifb.D = '0; ifb.Shift_En = 0; ifb.Start = 0; ifb.Mode = 2'b00; ifb.Serial_In = 0;
        Reset_n = 1'b0;

        // Reset state
        #12;
        chk("rst_data", 32'(ifa.Data_Out), 32'h0);
        chk("rst_cnt",  32'(ifa.Bit_Cnt),  32'h0);
        chk("rst_busy", 32'(ifa.Busy),     32'h0);
        chk("rst_done", 32'(ifa.Done),     32'h0);
        Reset_n = 1'b1;
        tick();

        // Single Shift_En step, zero fill
        ifa.D = 9'h1A5; ifa.Load = 1; tick(); ifa.Load = 0;
        chk("ld_data", 32'(ifa.Data_Out),   32'h1A5);
        chk("ld_sout", 32'(ifa.Serial_Out), 32'h1);
        ifa.Mode = 2'b00; ifa.Shift_En = 1; tick(); ifa.Shift_En = 0;
        chk("step_data", 32'(ifa.Data_Out),   32'h14A);
        chk("step_sout", 32'(ifa.Serial_Out), 32'h1);
        chk("step_busy", 32'(ifa.Busy),       32'h0);
        chk("step_done", 32'(ifa.Done),       32'h0);
        chk("step_cnt",  32'(ifa.Bit_Cnt),    32'h0);

        // Rotate burst
        ifa.D = 9'h1A5; ifa.Load = 1; tick(); ifa.Load = 0;
        ifa.Mode = 2'b01; ifa.Start = 1; tick(); ifa.Start = 0;
        exp_bits = 9'b1_1010_0101;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 9; i++) begin
            chk("rot_sout", 32'(ifa.Serial_Out), 32'(exp_bits[8-i]));
            if (ifa.Busy) busy_n++;
            if (ifa.Done) done_n++;
            tick();
        end
        chk("rot_done", 32'(ifa.Done),     32'h1);
        chk("rot_data", 32'(ifa.Data_Out), 32'h1A5);
        chk("rot_cnt",  32'(ifa.Bit_Cnt),  32'd9);
        chk("rot_busy_end", 32'(ifa.Busy), 32'h0);
        if (ifa.Done) done_n++;
        tick();
        chk("rot_done_clr", 32'(ifa.Done), 32'h0);
        chk("rot_cnt_hold", 32'(ifa.Bit_Cnt), 32'd9);
        chk("rot_busy_n", 32'(busy_n), 32'd9);
        chk("rot_done_n", 32'(done_n), 32'd1);

        // Serial_In burst, then Load during DONE
        ifa.D = 9'h000; ifa.Load = 1; tick(); ifa.Load = 0;
        ifa.Mode = 2'b10; ifa.Start = 1; tick(); ifa.Start = 0;
        sin_bits = 9'b1_0110_0111;
        for (int i = 0; i < 9; i++) begin
            ifa.Serial_In = sin_bits[8-i];
            tick();
        end
        ifa.Serial_In = 0;
        chk("sin_done", 32'(ifa.Done),     32'h1);
        chk("sin_data", 32'(ifa.Data_Out), 32'h167);
        ifa.D = 9'h055; ifa.Load = 1; tick(); ifa.Load = 0;
        chk("dload_data", 32'(ifa.Data_Out), 32'h055);
        chk("dload_cnt",  32'(ifa.Bit_Cnt),  32'h0);
        chk("dload_done", 32'(ifa.Done),     32'h0);

        // Abort a burst with Load on the 4th shift edge
        ifa.D = 9'h1A5; ifa.Load = 1; tick(); ifa.Load = 0;
        ifa.Mode = 2'b00; ifa.Start = 1; tick(); ifa.Start = 0;
        tick(); tick(); tick();
        chk("abt_cnt3", 32'(ifa.Bit_Cnt), 32'd3);
        ifa.D = 9'h0F0; ifa.Load = 1; tick(); ifa.Load = 0;
        chk("abt_data", 32'(ifa.Data_Out), 32'h0F0);
        chk("abt_cnt",  32'(ifa.Bit_Cnt),  32'h0);
        chk("abt_busy", 32'(ifa.Busy),     32'h0);
        chk("abt_done", 32'(ifa.Done),     32'h0);
        tick();
        chk("abt_done2", 32'(ifa.Done),     32'h0);
        chk("abt_hold",  32'(ifa.Data_Out), 32'h0F0);

        // Back-to-back bursts with Start held high
        ifa.Start = 1; ifa.Mode = 2'b01;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (ifa.Busy) busy_n++;
            if (ifa.Done) done_n++;
            if (i == 11) chk("b2b_busy11", 32'(ifa.Busy), 32'h1);
        end
        ifa.Start = 0;
        chk("b2b_busy_n", 32'(busy_n), 32'd18);
        chk("b2b_done_n", 32'(done_n), 32'd2);
        tick();

        // Asynchronous reset in the middle of a burst
        ifa.D = 9'h1A5; ifa.Load = 1; tick(); ifa.Load = 0;
        ifa.Mode = 2'b01; ifa.Start = 1; tick(); ifa.Start = 0;
        tick(); tick(); tick();
        chk("mid_busy", 32'(ifa.Busy), 32'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_data", 32'(ifa.Data_Out),   32'h0);
        chk("arst_cnt",  32'(ifa.Bit_Cnt),    32'h0);
        chk("arst_busy", 32'(ifa.Busy),       32'h0);
        chk("arst_done", 32'(ifa.Done),       32'h0);
        chk("arst_sout", 32'(ifa.Serial_Out), 32'h0);
        #3;
        Reset_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(ifa.Busy), 32'h0);
        chk("post_rst_done", 32'(ifa.Done), 32'h0);
        chk("post_rst_data", 32'(ifa.Data_Out), 32'h0);

        // LSB-first instance: zero-fill burst from 9'h001
        ifb.D = 9'h001; ifb.Load = 1; tick(); ifb.Load = 0;
        ifb.Mode = 2'b00; ifb.Start = 1; tick(); ifb.Start = 0;
        for (int i = 0; i < 9; i++) begin
            chk("lsb_sout", 32'(ifb.Serial_Out), (i == 0) ? 32'h1 : 32'h0);
            tick();
        end
        chk("lsb_done", 32'(ifb.Done),     32'h1);
        chk("lsb_data", 32'(ifb.Data_Out), 32'h0);
        chk("lsb_cnt",  32'(ifb.Bit_Cnt),  32'd9);
        tick();

        // Load beats Start and Shift_En in IDLE
        ifb.D = 9'h0AA; ifb.Load = 1; ifb.Start = 1; ifb.Shift_En = 1;
        tick();
        ifb.Load = 0; ifb.Start = 0; ifb.Shift_En = 0;
        chk("prio_data", 32'(ifb.Data_Out), 32'h0AA);
        chk("prio_busy", 32'(ifb.Busy),     32'h0);
        chk("prio_cnt",  32'(ifb.Bit_Cnt),  32'h0);
        tick();
        chk("prio_hold", 32'(ifb.Data_Out), 32'h0AA);
        chk("prio_busy2", 32'(ifb.Busy),    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
